dht11_sensor_emulator: RTL and testbench
========================================

# dht11_sensor_emulator

Synthesizable DHT11 sensor model that acts as the responder on the single-wire DHT11 bus. It detects the host start pulse, then drives the response preamble and a 40-bit data frame with DHT11 pulse-width encoding. It is used in loopback and bench setups to exercise the DHT11 host receiver IP without a physical sensor. The bus is driven open-drain: the block only ever pulls the line low or releases it.

## Interface
- CLKS_PER_US, 100: clk cycles per microsecond tick.
- START_LOW_US, 18000: minimum host low time, in µs, accepted as a valid start.
- RESP_DELAY_US, 30: wait after host release before the response begins.
- clk  input  1  system clock.
- reset_p  input  1  reset, asynchronous, active-high.
- dht_in  input  1  bus level as sampled from the pad; asynchronous.
- dht_oe  output  1  1 = pull bus low; 0 = release.
- hum_int, hum_dec, tmp_int, tmp_dec  input  8 each  values to report.
- busy  output  1  high from accepted start until frame end.
- frame_done  output  1  one-cycle pulse when the frame completes.

## Operation
- dht_in passes through a 2-FF synchronizer, then one history FF. These give fall/rise strobes.
- States:
  - IDLE: oe=0. On a fall strobe, go to HOST_LOW and clear the µs counter.
  - HOST_LOW: count µs while the line is low. The count saturates at START_LOW_US.
    - On a rise strobe with count ≥ START_LOW_US: go to RESP_DLY and latch the four data bytes plus the checksum.
    - On a rise strobe with count < START_LOW_US: return to IDLE.
  - RESP_DLY: oe=0 for RESP_DELAY_US.
  - RESP_LOW: oe=1 for 80 µs.
  - RESP_HIGH: oe=0 for 80 µs.
  - BIT_LOW: oe=1 for 50 µs.
  - BIT_HIGH: oe=0 for 26 µs if the current bit is 0, or 70 µs if it is 1.
    - Then increment bit_idx.
    - If bit_idx reaches 40, go to END_LOW; otherwise go to BIT_LOW.
  - END_LOW: oe=1 for 50 µs. Then go to IDLE and pulse frame_done.
- Frame order is MSB first: hum_int, hum_dec, tmp_int, tmp_dec, checksum.
- checksum = (hum_int+hum_dec+tmp_int+tmp_dec) mod 256, computed as an 8-bit wrapping sum.
- The latched data is held for the entire frame. Input changes mid-frame do not affect it.
- dht_in strobes are ignored in every state except IDLE and HOST_LOW, because the bus then reflects the block's own drive.
- busy = 1 in RESP_DLY through END_LOW inclusive.

## Timing
- Reset values:
  - dht_oe=0, busy=0, frame_done=0, state=IDLE.
  - Synchronizer FFs reset to 1, the idle bus level, so no false fall is seen at reset release.
- Reset asserted mid-frame releases the bus (dht_oe=0) asynchronously. No frame_done is produced.
- Fall strobe appears 3 cycles after dht_in falls (2 sync FFs + 1 history FF).
- The tick prescaler restarts on every state entry. Each phase of N µs therefore lasts exactly N·CLKS_PER_US cycles.
- dht_oe is registered. It changes on the cycle after the state transition.
- Frame length from host release = RESP_DELAY_US + 160 + 40·50 + Σhigh + 50 µs, plus fixed sync latency.
- µs counter width: ≥ clog2(START_LOW_US+1); 15 bits at defaults.
- bit_idx: 6 bits, 0..39.

## Structure
- Shared package dht11_pkg holds:
  - the state enum;
  - phase constants RESP_LOW_US=80, RESP_HIGH_US=80, BIT_LOW_US=50, BIT0_HIGH_US=26, BIT1_HIGH_US=70, END_LOW_US=50;
  - FRAME_BITS=40.
- Sub-module dht11_us_tick: a prescaler with a synchronous clear that outputs a 1-cycle tick every CLKS_PER_US cycles.

## Test plan
All scenarios use CLKS_PER_US=4, START_LOW_US=20, RESP_DELAY_US=30. The bench models a pull-up, so the bus level = ~dht_oe & host_drive.

- Valid start with data 0x37,0x00,0x19,0x05:
  - Host holds the bus low 25 µs, then releases it.
  - Required: decoded bits 0x37 0x00 0x19 0x05 0x55, a 30 µs delay, 80/80 µs preamble, exact 26/70 µs highs, and one frame_done pulse.
- Short start of 10 µs low: dht_oe stays 0, busy stays 0, and the state returns to IDLE.
- Checksum wrap with data 0xFF,0xFF,0x01,0x02: checksum byte = 0x01.
- Data inputs changed to 0x00 during BIT_LOW of bit 5: the transmitted frame still matches the values latched at start.
- reset_p pulsed during bit 20: dht_oe=0 within the same cycle, with no frame_done. A subsequent valid start produces a full, correct frame.
- Back-to-back: a second 25 µs start issued 100 µs after frame_done produces a second complete frame. A host low issued while busy=1 is ignored.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared types and timing constants for the DHT11 responder model.
package dht11_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_LOW,
    S_RESP_DLY,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_END_LOW
  } dht11_state_e;

  localparam int unsigned RESP_LOW_US  = 80;
  localparam int unsigned RESP_HIGH_US = 80;
  localparam int unsigned BIT_LOW_US   = 50;
  localparam int unsigned BIT0_HIGH_US = 26;
  localparam int unsigned BIT1_HIGH_US = 70;
  localparam int unsigned END_LOW_US   = 50;
  localparam int unsigned FRAME_BITS   = 40;

  // The us counter serves both the start-pulse measurement and every timed phase.
  function automatic int unsigned us_cnt_width(input int unsigned start_low_us,
                                               input int unsigned resp_delay_us);
    int unsigned m;
    m = start_low_us;
    if (resp_delay_us > m) m = resp_delay_us;
    if (RESP_LOW_US > m)   m = RESP_LOW_US;
    if (RESP_HIGH_US > m)  m = RESP_HIGH_US;
    if (BIT1_HIGH_US > m)  m = BIT1_HIGH_US;
    if (BIT_LOW_US > m)    m = BIT_LOW_US;
    return $clog2(m + 1);
  endfunction

  function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d);
    return 8'(a + b + c + d);
  endfunction

endpackage

// File: rtl/dht11_sensor_emulator_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLKS_PER_US cycles, restartable.
module dht11_us_tick #(
  parameter int unsigned CLKS_PER_US = 100
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

  logic [CW-1:0] cnt_q, cnt_d, cur;

  // The clear cycle is treated as count 0 of the new period, so N ticks span exactly N*CLKS_PER_US cycles.
  always_comb begin
    cur    = clr_i ? '0 : cnt_q;
    tick_o = (cur == LAST);
    cnt_d  = tick_o ? '0 : cur + CW'(1);
  end

  // Prescaler count register.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dht11_sensor_emulator.sv
// DHT11 responder: detects the host start pulse and answers with preamble plus 40-bit frame.
module dht11_sensor_emulator
  import dht11_pkg::*;
#(
  parameter int unsigned CLKS_PER_US   = 100,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       dht_in,
  output logic       dht_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned US_W = us_cnt_width(START_LOW_US, RESP_DELAY_US);
  localparam logic [US_W-1:0] US_ONE   = US_W'(1);
  localparam logic [US_W-1:0] START_LO = US_W'(START_LOW_US);

  logic              sync1_q, sync2_q, hist_q;
  logic              fall_s, rise_s;
  dht11_state_e      state_q;
  logic [US_W-1:0]   us_q;
  logic [5:0]        bit_idx_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic              oe_q, busy_q, done_q, entry_q;
  logic              tick;
  logic [US_W-1:0]   phase_len;
  logic              phase_end;

  dht11_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .clr_i   (entry_q),
    .tick_o  (tick)
  );

  // Bus synchronizer plus history stage; reset to the released (high) level.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= dht_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign fall_s = hist_q & ~sync2_q;
  assign rise_s = ~hist_q & sync2_q;

  // Length in us of the current timed phase.
  always_comb begin
    phase_len = '0;
    case (state_q)
      S_RESP_DLY:  phase_len = US_W'(RESP_DELAY_US);
      S_RESP_LOW:  phase_len = US_W'(RESP_LOW_US);
      S_RESP_HIGH: phase_len = US_W'(RESP_HIGH_US);
      S_BIT_LOW:   phase_len = US_W'(BIT_LOW_US);
      S_BIT_HIGH:  phase_len = frame_q[FRAME_BITS-1] ? US_W'(BIT1_HIGH_US) : US_W'(BIT0_HIGH_US);
      S_END_LOW:   phase_len = US_W'(END_LOW_US);
      default:     phase_len = '0;
    endcase
  end

  assign phase_end = tick && (us_q == phase_len - US_ONE);

  // Responder FSM with registered bus drive, busy and frame_done.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q   <= S_IDLE;
      us_q      <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      entry_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      entry_q <= 1'b0;
      if (tick && state_q != S_IDLE && state_q != S_HOST_LOW)
        us_q <= phase_end ? '0 : us_q + US_ONE;
      case (state_q)
        S_IDLE: begin
          if (fall_s) begin
            state_q <= S_HOST_LOW;
            us_q    <= '0;
            entry_q <= 1'b1;
          end
        end
        S_HOST_LOW: begin
          if (rise_s) begin
            us_q    <= '0;
            entry_q <= 1'b1;
            if (us_q >= START_LO) begin
              state_q   <= S_RESP_DLY;
              busy_q    <= 1'b1;
              bit_idx_q <= '0;
              frame_q   <= {hum_int, hum_dec, tmp_int, tmp_dec,
                            dht11_checksum(hum_int, hum_dec, tmp_int, tmp_dec)};
            end else begin
              state_q <= S_IDLE;
            end
          end else if (tick && us_q < START_LO) begin
            us_q <= us_q + US_ONE;
          end
        end
        S_RESP_DLY: if (phase_end) begin
          state_q <= S_RESP_LOW;  oe_q <= 1'b1; entry_q <= 1'b1;
        end
        S_RESP_LOW: if (phase_end) begin
          state_q <= S_RESP_HIGH; oe_q <= 1'b0; entry_q <= 1'b1;
        end
        S_RESP_HIGH: if (phase_end) begin
          state_q <= S_BIT_LOW;   oe_q <= 1'b1; entry_q <= 1'b1;
        end
        S_BIT_LOW: if (phase_end) begin
          state_q <= S_BIT_HIGH;  oe_q <= 1'b0; entry_q <= 1'b1;
        end
        S_BIT_HIGH: if (phase_end) begin
          frame_q   <= {frame_q[FRAME_BITS-2:0], 1'b0};
          bit_idx_q <= bit_idx_q + 6'd1;
          oe_q      <= 1'b1;
          entry_q   <= 1'b1;
          state_q   <= (bit_idx_q == 6'(FRAME_BITS - 1)) ? S_END_LOW : S_BIT_LOW;
        end
        S_END_LOW: if (phase_end) begin
          state_q   <= S_IDLE;
          oe_q      <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          bit_idx_q <= '0;
          entry_q   <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dht_oe     = oe_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Directed bench for dht11_sensor_emulator with an open-drain bus model.
module tb_dht11_sensor_emulator;
  import dht11_pkg::*;

  localparam int unsigned CPU = 4;
  localparam int unsigned SL  = 20;
  localparam int unsigned RD  = 30;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       host_drive = 1'b1;
  logic [7:0] hi = '0, hd = '0, ti = '0, td = '0;
  logic       dht_oe, busy, frame_done, dht_in;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  assign dht_in = ~dht_oe & host_drive;

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  dht11_sensor_emulator #(
    .CLKS_PER_US   (CPU),
    .START_LOW_US  (SL),
    .RESP_DELAY_US (RD)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .dht_in     (dht_in),
    .dht_oe     (dht_oe),
    .hum_int    (hi),
    .hum_dec    (hd),
    .tmp_int    (ti),
    .tmp_dec    (td),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles until dht_oe leaves the given level, bounded.
  task automatic measure(input logic level, output int cyc);
    cyc = 0;
    while (dht_oe === level && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic host_start(input int us);
    host_drive = 1'b0;
    step(us * CPU);
    host_drive = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [7:0] ck,
                           input int change_bit, input int abort_bit, input int host_bit);
    logic [39:0] exp_f, rx;
    int cyc, bad_low, bad_high, d0;
    logic b_exp;
    exp_f = {a, b, c, d, ck};
    rx = '0;
    bad_low = 0;
    bad_high = 0;
    hi = a; hd = b; ti = c; td = d;
    d0 = done_cnt;
    host_start(25);
    measure(1'b0, cyc);
    check("resp_delay", cyc, RD * CPU + 3);
    check("busy_in_frame", busy, 1);
    measure(1'b1, cyc);
    check("resp_low", cyc, 80 * CPU);
    measure(1'b0, cyc);
    check("resp_high", cyc, 80 * CPU);
    for (int i = 0; i < 40; i++) begin
      if (i == abort_bit) begin
        step(10);
        reset_p = 1'b1;
        #1;
        check("abort_oe", dht_oe, 0);
        check("abort_busy", busy, 0);
        step(3);
        reset_p = 1'b0;
        step(300);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", dut.state_q, S_IDLE);
        return;
      end
      if (i == change_bit) begin
        hi = '0; hd = '0; ti = '0; td = '0;
      end
      if (i == host_bit) begin
        fork
          begin
            host_drive = 1'b0;
            step(100);
            host_drive = 1'b1;
          end
        join_none
      end
      measure(1'b1, cyc);
      if (cyc != 200) bad_low++;
      measure(1'b0, cyc);
      b_exp = exp_f[39 - i];
      if (cyc != (b_exp ? 280 : 104)) bad_high++;
      rx = {rx[38:0], (cyc >= 180)};
    end
    check("bit_low_len", bad_low, 0);
    check("bit_high_len", bad_high, 0);
    check("frame_data", rx, exp_f);
    measure(1'b1, cyc);
    check("end_low", cyc, 200);
    check("done_pulse", frame_done, 1);
    check("busy_clear", busy, 0);
    step(1);
    check("done_one_cycle", frame_done, 0);
    step(20);
    check("done_count", done_cnt - d0, 1);
    check("back_idle", dut.state_q, S_IDLE);
  endtask

  initial begin
    int oe_seen, busy_seen;
    step(3);
    check("rst_oe", dht_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_state", dut.state_q, S_IDLE);
    reset_p = 1'b0;
    step(20);
    check("no_false_start", dut.state_q, S_IDLE);

    // Valid start; inputs cleared during BIT_LOW of bit 5 must not alter the frame.
    run_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'h55, 5, -1, -1);

    // Back-to-back start 100 us after frame_done, checksum wrap, host low while busy.
    step(379);
    run_frame(8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01, -1, -1, 10);

    // Short start is rejected.
    step(40);
    host_start(10);
    oe_seen = 0;
    busy_seen = 0;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if (dht_oe !== 1'b0) oe_seen = 1;
      if (busy !== 1'b0) busy_seen = 1;
    end
    check("short_oe", oe_seen, 0);
    check("short_busy", busy_seen, 0);
    check("short_idle", dut.state_q, S_IDLE);

    // Reset during bit 20, then a full frame afterwards.
    run_frame(8'h37, 8'h00, 8'h19, 8'h05, 8'h55, -1, 20, -1);
    run_frame(8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'hFE, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
